// File: rtl/pe_mac_os.sv
// Output-stationary systolic PE: signed fixed-point MAC over a programmable-length tile,
// emitting one rounded, saturated result per tile; X/W/valid forwarded with 1-cycle latency.
module pe_mac_os #(
   parameter int D_W      = 8,
   parameter int FRAC     = 5,
   parameter int K_W      = 8,
   parameter int ACC_W    = 2*D_W + K_W,
   parameter int MUL_PIPE = 0
) (
   input  logic           I_CLK,
   input  logic           I_ASYN_RSTN,
   input  logic           I_SYNC_RSTN,
   input  logic           I_CLR,
   input  logic           I_VLD,
   input  logic [D_W-1:0] I_X,
   input  logic [D_W-1:0] I_W,
   input  logic [K_W-1:0] I_LEN,
   output logic           O_VLD,
   output logic [D_W-1:0] O_X,
   output logic [D_W-1:0] O_W,
   output logic [D_W-1:0] O_D,
   output logic           O_D_VLD,
   output logic           O_SAT,
   output logic           O_BUSY
);

   localparam int RW = ACC_W + 1;
   localparam logic signed [RW-1:0] SAT_MAX = RW'((2**(D_W-1)) - 1);
   localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                  state_q, state_d;
   logic [K_W-1:0]          in_cnt_q, in_cnt_d;
   logic [K_W-1:0]          len_q, len_d;
   logic                    fvld_q, fvld_d;
   logic [D_W-1:0]          fx_q, fx_d, fw_q, fw_d;
   logic signed [ACC_W-1:0] p_q, p_d;
   logic                    pv_q, pv_d, pl_q, pl_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [D_W-1:0]          od_q, od_d;
   logic                    odv_q, odv_d, osat_q, osat_d;

   logic                    in_last, mac_vld;
   logic signed [2*D_W-1:0] p_now;
   logic signed [ACC_W-1:0] p_ext, acc_p, acc_n;
   logic                    acc_vld, acc_last;
   logic signed [RW-1:0]    acc_x, rnd_r;
   logic [D_W-1:0]          res;
   logic                    clip;

   assign mac_vld = I_VLD & ~I_CLR;
   assign p_now   = $signed(I_X) * $signed(I_W);
   assign p_ext   = {{(ACC_W-2*D_W){p_now[2*D_W-1]}}, p_now};

   // Optional multiplier register: the accumulator sees the product, its valid and last tag together
   assign acc_p    = (MUL_PIPE != 0) ? p_q  : p_ext;
   assign acc_vld  = (MUL_PIPE != 0) ? pv_q : mac_vld;
   assign acc_last = (MUL_PIPE != 0) ? pl_q : in_last;
   assign acc_n    = acc_q + acc_p;
   assign acc_x    = {acc_n[ACC_W-1], acc_n};

   if (FRAC > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = RW'(2**(FRAC-1));
      assign rnd_r = (acc_x + HALF) >>> FRAC;
   end else begin : g_nornd
      assign rnd_r = acc_x;
   end

   always_comb begin
      res  = rnd_r[D_W-1:0];
      clip = 1'b0;
      if (rnd_r > SAT_MAX) begin
         res  = SAT_MAX[D_W-1:0];
         clip = 1'b1;
      end else if (rnd_r < SAT_MIN) begin
         res  = SAT_MIN[D_W-1:0];
         clip = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      in_cnt_d = in_cnt_q;
      len_d    = len_q;
      in_last  = 1'b0;
      fvld_d   = I_VLD;
      fx_d     = I_VLD ? I_X : fx_q;
      fw_d     = I_VLD ? I_W : fw_q;
      p_d      = p_ext;
      pv_d     = 1'b0;
      pl_d     = 1'b0;
      acc_d    = acc_q;
      od_d     = od_q;
      odv_d    = 1'b0;
      osat_d   = osat_q;

      if (I_CLR) begin
         state_d  = ST_IDLE;
         in_cnt_d = '0;
      end else if (I_VLD) begin
         if (state_q == ST_IDLE) begin
            len_d = (I_LEN == '0) ? K_W'(1) : I_LEN;
            if (len_d == K_W'(1)) begin
               in_last = 1'b1;
            end else begin
               in_cnt_d = K_W'(1);
               state_d  = ST_RUN;
            end
         end else if ((in_cnt_q + K_W'(1)) == len_q) begin
            in_last  = 1'b1;
            in_cnt_d = '0;
            state_d  = ST_IDLE;
         end else begin
            in_cnt_d = in_cnt_q + K_W'(1);
         end
      end

      pv_d = mac_vld;
      pl_d = in_last;

      if (I_CLR) begin
         acc_d = '0;
      end else if (acc_vld) begin
         if (acc_last) begin
            acc_d  = '0;
            od_d   = res;
            odv_d  = 1'b1;
            osat_d = clip;
         end else begin
            acc_d = acc_n;
         end
      end

      // Synchronous reset overrides every next-state value
      if (!I_SYNC_RSTN) begin
         state_d  = ST_IDLE;
         in_cnt_d = '0;
         len_d    = '0;
         fvld_d   = 1'b0;
         fx_d     = '0;
         fw_d     = '0;
         p_d      = '0;
         pv_d     = 1'b0;
         pl_d     = 1'b0;
         acc_d    = '0;
         od_d     = '0;
         odv_d    = 1'b0;
         osat_d   = 1'b0;
      end
   end

   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN) begin
         state_q  <= ST_IDLE;
         in_cnt_q <= '0;
         len_q    <= '0;
         fvld_q   <= 1'b0;
         fx_q     <= '0;
         fw_q     <= '0;
         p_q      <= '0;
         pv_q     <= 1'b0;
         pl_q     <= 1'b0;
         acc_q    <= '0;
         od_q     <= '0;
         odv_q    <= 1'b0;
         osat_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_cnt_q <= in_cnt_d;
         len_q    <= len_d;
         fvld_q   <= fvld_d;
         fx_q     <= fx_d;
         fw_q     <= fw_d;
         p_q      <= p_d;
         pv_q     <= pv_d;
         pl_q     <= pl_d;
         acc_q    <= acc_d;
         od_q     <= od_d;
         odv_q    <= odv_d;
         osat_q   <= osat_d;
      end
   end

   assign O_VLD   = fvld_q;
   assign O_X     = fx_q;
   assign O_W     = fw_q;
   assign O_D     = od_q;
   assign O_D_VLD = odv_q;
   assign O_SAT   = osat_q;
   // A tile stays busy while its last product still waits in the multiplier register
   assign O_BUSY  = (state_q == ST_RUN) | ((MUL_PIPE != 0) & pv_q & pl_q);

endmodule
